// File: rtl/decode_stage.sv
// ID stage: decodes one RV32I(+M) instruction per cycle into the control bundle,
// holds it in the ID/EX register and stalls load-dependent instructions.
module decode_stage #(
  parameter int          XLEN         = 32,
  parameter bit          ENABLE_M     = 1'b0,
  parameter int unsigned LOAD_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_alu_control,
  output logic            out_alu_src,
  output logic [2:0]      out_imm_src,
  output logic [1:0]      out_result_src,
  output logic [3:0]      out_mem_op,
  output logic            out_reg_write,
  output logic            out_jump,
  output logic            out_branch,
  output logic            out_illegal
);

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] alu_control;
    logic       alu_src;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [3:0] mem_op;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  use_rs1;
    logic  use_rs2;
  } dec_t;

  localparam logic [1:0] BUBBLES = 2'(LOAD_BUBBLES);

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    opcode     = instr[6:0];
    f3         = instr[14:12];
    f7         = instr[31:25];
    d          = '0;
    bad        = 1'b0;
    d.ctrl.rd  = instr[11:7];
    d.ctrl.rs1 = instr[19:15];
    d.ctrl.rs2 = instr[24:20];
    case (opcode)
      7'b0110111: begin // LUI
        d.ctrl.alu_control = 7'd16;
        d.ctrl.alu_src     = 1'b1;
        d.ctrl.imm_src     = 3'd4;
        d.ctrl.reg_write   = 1'b1;
      end
      7'b0010111: begin // AUIPC
        d.ctrl.imm_src    = 3'd4;
        d.ctrl.result_src = 2'd3;
        d.ctrl.reg_write  = 1'b1;
      end
      7'b1101111: begin // JAL
        d.ctrl.imm_src    = 3'd3;
        d.ctrl.result_src = 2'd2;
        d.ctrl.jump       = 1'b1;
        d.ctrl.reg_write  = 1'b1;
      end
      7'b1100111: begin // JALR
        if (f3 == 3'b000) begin
          d.ctrl.alu_src    = 1'b1;
          d.ctrl.result_src = 2'd2;
          d.ctrl.jump       = 1'b1;
          d.ctrl.reg_write  = 1'b1;
          d.use_rs1         = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      7'b1100011: begin // BRANCH
        d.ctrl.imm_src = 3'd2;
        d.ctrl.branch  = 1'b1;
        d.use_rs1      = 1'b1;
        d.use_rs2      = 1'b1;
        case (f3)
          3'b000:  d.ctrl.alu_control = 7'd10;
          3'b001:  d.ctrl.alu_control = 7'd11;
          3'b100:  d.ctrl.alu_control = 7'd12;
          3'b101:  d.ctrl.alu_control = 7'd13;
          3'b110:  d.ctrl.alu_control = 7'd14;
          3'b111:  d.ctrl.alu_control = 7'd15;
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin // LOAD
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.result_src = 2'd1;
        d.ctrl.reg_write  = 1'b1;
        d.use_rs1         = 1'b1;
        case (f3)
          3'b000:  d.ctrl.mem_op = 4'd6;
          3'b001:  d.ctrl.mem_op = 4'd5;
          3'b010:  d.ctrl.mem_op = 4'd4;
          3'b100:  d.ctrl.mem_op = 4'd7;
          3'b101:  d.ctrl.mem_op = 4'd8;
          default: bad = 1'b1;
        endcase
      end
      7'b0100011: begin // STORE
        d.ctrl.alu_src = 1'b1;
        d.ctrl.imm_src = 3'd1;
        d.use_rs1      = 1'b1;
        d.use_rs2      = 1'b1;
        case (f3)
          3'b000:  d.ctrl.mem_op = 4'd3;
          3'b001:  d.ctrl.mem_op = 4'd2;
          3'b010:  d.ctrl.mem_op = 4'd1;
          default: bad = 1'b1;
        endcase
      end
      7'b0010011: begin // OP-IMM; shift-immediates need a clean funct7
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.use_rs1        = 1'b1;
        case (f3)
          3'b000: d.ctrl.alu_control = 7'd0;
          3'b010: d.ctrl.alu_control = 7'd5;
          3'b011: d.ctrl.alu_control = 7'd7;
          3'b100: d.ctrl.alu_control = 7'd4;
          3'b110: d.ctrl.alu_control = 7'd3;
          3'b111: d.ctrl.alu_control = 7'd2;
          3'b001: begin
            if (f7 == 7'b0000000) d.ctrl.alu_control = 7'd6;
            else                  bad = 1'b1;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      d.ctrl.alu_control = 7'd8;
            else if (f7 == 7'b0100000) d.ctrl.alu_control = 7'd9;
            else                       bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0110011: begin // OP
        d.ctrl.reg_write = 1'b1;
        d.use_rs1        = 1'b1;
        d.use_rs2        = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d.ctrl.alu_control = 7'd0;
            3'b001:  d.ctrl.alu_control = 7'd6;
            3'b010:  d.ctrl.alu_control = 7'd5;
            3'b011:  d.ctrl.alu_control = 7'd7;
            3'b100:  d.ctrl.alu_control = 7'd4;
            3'b101:  d.ctrl.alu_control = 7'd8;
            3'b110:  d.ctrl.alu_control = 7'd3;
            3'b111:  d.ctrl.alu_control = 7'd2;
            default: bad = 1'b1;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  d.ctrl.alu_control = 7'd1;
            3'b101:  d.ctrl.alu_control = 7'd9;
            default: bad = 1'b1;
          endcase
        end else if ((f7 == 7'b0000001) && ENABLE_M) begin
          d.ctrl.alu_control = 7'd17 + {4'd0, f3};
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      d              = '0;
      d.ctrl.illegal = 1'b1;
    end
    return d;
  endfunction

  dec_t            dec;
  logic            hazard_stall;
  logic            accept;
  logic            load_consumed;

  logic            out_valid_d, out_valid_q;
  ctrl_t           bundle_d, bundle_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [1:0]      cnt_d, cnt_q;
  logic [4:0]      haz_rd_d, haz_rd_q;

  assign dec = decode(in_instr);

  assign hazard_stall = (cnt_q != 2'd0) && in_valid &&
                        ((dec.use_rs1 && (dec.ctrl.rs1 == haz_rd_q)) ||
                         (dec.use_rs2 && (dec.ctrl.rs2 == haz_rd_q)));

  assign in_ready      = (~out_valid_q | out_ready) & ~hazard_stall & ~flush;
  assign accept        = in_valid & in_ready;
  assign load_consumed = out_valid_q && out_ready &&
                         (bundle_q.mem_op >= 4'd4) && (bundle_q.mem_op <= 4'd8) &&
                         (bundle_q.rd != 5'd0);

  // Next-state for the ID/EX register and the load-use counter; flush wins over everything.
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    haz_rd_d    = haz_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
      cnt_d       = 2'd0;
    end else begin
      if (accept) begin
        out_valid_d = 1'b1;
        bundle_d    = dec.ctrl;
        pc_d        = in_pc;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (load_consumed) begin
        cnt_d    = BUBBLES;
        haz_rd_d = bundle_q.rd;
      end else if (cnt_q != 2'd0) begin
        cnt_d = cnt_q - 2'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      pc_q        <= '0;
      cnt_q       <= 2'd0;
      haz_rd_q    <= 5'd0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      haz_rd_q    <= haz_rd_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = pc_q;
  assign out_rd          = bundle_q.rd;
  assign out_rs1         = bundle_q.rs1;
  assign out_rs2         = bundle_q.rs2;
  assign out_alu_control = bundle_q.alu_control;
  assign out_alu_src     = bundle_q.alu_src;
  assign out_imm_src     = bundle_q.imm_src;
  assign out_result_src  = bundle_q.result_src;
  assign out_mem_op      = bundle_q.mem_op;
  assign out_reg_write   = bundle_q.reg_write;
  assign out_jump        = bundle_q.jump;
  assign out_branch      = bundle_q.branch;
  assign out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: dut uses defaults (no M, 1 bubble),
// dut_m shares its stimulus with ENABLE_M=1 and LOAD_BUBBLES=2.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_alu_src, out_reg_write, out_jump, out_branch, out_illegal;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [6:0]  out_alu_control;
  logic [2:0]  out_imm_src;
  logic [1:0]  out_result_src;
  logic [3:0]  out_mem_op;

  logic        m_in_ready, m_out_valid, m_out_alu_src, m_out_reg_write, m_out_jump, m_out_branch, m_out_illegal;
  logic [31:0] m_out_pc;
  logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
  logic [6:0]  m_out_alu_control;
  logic [2:0]  m_out_imm_src;
  logic [1:0]  m_out_result_src;
  logic [3:0]  m_out_mem_op;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] I_ADD     = 32'h002081B3;
  localparam logic [31:0] I_SUB     = 32'h402081B3;
  localparam logic [31:0] I_SRAI    = 32'h4020D193;
  localparam logic [31:0] I_BEQ     = 32'h00208463;
  localparam logic [31:0] I_LW      = 32'h0000A283;
  localparam logic [31:0] I_ADD_DEP = 32'h00028333;
  localparam logic [31:0] I_ADD_IND = 32'h00208333;
  localparam logic [31:0] I_OR      = 32'h0020E3B3;
  localparam logic [31:0] I_AND     = 32'h0020F433;
  localparam logic [31:0] I_MUL     = 32'h022081B3;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_alu_control(out_alu_control), .out_alu_src(out_alu_src), .out_imm_src(out_imm_src),
    .out_result_src(out_result_src), .out_mem_op(out_mem_op), .out_reg_write(out_reg_write),
    .out_jump(out_jump), .out_branch(out_branch), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .LOAD_BUBBLES(2)) dut_m (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_pc(m_out_pc), .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
    .out_alu_control(m_out_alu_control), .out_alu_src(m_out_alu_src), .out_imm_src(m_out_imm_src),
    .out_result_src(m_out_result_src), .out_mem_op(m_out_mem_op), .out_reg_write(m_out_reg_write),
    .out_jump(m_out_jump), .out_branch(m_out_branch), .out_illegal(m_out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    reset    = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_alu", {25'd0, out_alu_control}, 32'd0);
    check("rst_rd", {27'd0, out_rd}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    offer(I_ADD, 32'h100);
    check("add_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_alu", {25'd0, out_alu_control}, 32'd0);
    check("add_wr", {31'd0, out_reg_write}, 32'd1);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    check("add_rs1", {27'd0, out_rs1}, 32'd1);
    check("add_rs2", {27'd0, out_rs2}, 32'd2);
    check("add_ill", {31'd0, out_illegal}, 32'd0);
    check("add_pc", out_pc, 32'h100);

    offer(I_SUB, 32'h104);
    check("sub_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    check("sub_alu", {25'd0, out_alu_control}, 32'd1);
    check("sub_pc", out_pc, 32'h104);

    offer(I_SRAI, 32'h108);
    tick();
    check("srai_alu", {25'd0, out_alu_control}, 32'd9);
    check("srai_src", {31'd0, out_alu_src}, 32'd1);

    offer(I_BEQ, 32'h10C);
    tick();
    check("beq_alu", {25'd0, out_alu_control}, 32'd10);
    check("beq_br", {31'd0, out_branch}, 32'd1);
    check("beq_wr", {31'd0, out_reg_write}, 32'd0);
    check("beq_imm", {29'd0, out_imm_src}, 32'd2);

    offer(I_LW, 32'h110);
    tick();
    check("lw_mem", {28'd0, out_mem_op}, 32'd4);
    check("lw_res", {30'd0, out_result_src}, 32'd1);
    check("lw_rd", {27'd0, out_rd}, 32'd5);
    in_valid = 1'b0;
    tick();
    check("lw_drain", {31'd0, out_valid}, 32'd0);
    offer(I_ADD_DEP, 32'h114);
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("stall_noacc", {31'd0, out_valid}, 32'd0);
    check("stall_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("dep_valid", {31'd0, out_valid}, 32'd1);
    check("dep_rd", {27'd0, out_rd}, 32'd6);
    check("dep_rs1", {27'd0, out_rs1}, 32'd5);

    offer(I_LW, 32'h118);
    tick();
    in_valid = 1'b0;
    tick();
    offer(I_ADD_IND, 32'h11C);
    check("nostall_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("ind_valid", {31'd0, out_valid}, 32'd1);
    check("ind_rs2", {27'd0, out_rs2}, 32'd2);
    tick();

    out_ready = 1'b0;
    offer(I_OR, 32'h1F0);
    check("or_ready", {31'd0, in_ready}, 32'd1);
    tick();
    offer(I_AND, 32'h200);
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_alu", {25'd0, out_alu_control}, 32'd3);
      check("bp_rd", {27'd0, out_rd}, 32'd7);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("and_alu", {25'd0, out_alu_control}, 32'd2);
    check("and_rd", {27'd0, out_rd}, 32'd8);
    check("and_pc", out_pc, 32'h200);

    do_reset();
    offer(I_LW, 32'h300);
    tick();
    offer(I_ADD_IND, 32'h304);
    tick();
    out_ready = 1'b0;
    flush     = 1'b1;
    offer(I_ADD_DEP, 32'h308);
    check("flush_ready", {31'd0, in_ready}, 32'd0);
    check("flush_m_ready", {31'd0, m_in_ready}, 32'd0);
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_m_valid", {31'd0, m_out_valid}, 32'd0);
    check("flush_hz_clr", {31'd0, m_in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("post_flush_valid", {31'd0, m_out_valid}, 32'd1);
    check("post_flush_rd", {27'd0, m_out_rd}, 32'd6);

    offer(I_MUL, 32'h400);
    tick();
    in_valid = 1'b0;
    check("mul_ill", {31'd0, out_illegal}, 32'd1);
    check("mul_wr", {31'd0, out_reg_write}, 32'd0);
    check("mul_alu", {25'd0, out_alu_control}, 32'd0);
    check("mulm_alu", {25'd0, m_out_alu_control}, 32'd17);
    check("mulm_wr", {31'd0, m_out_reg_write}, 32'd1);
    check("mulm_ill", {31'd0, m_out_illegal}, 32'd0);

    offer(32'h0, 32'h404);
    tick();
    in_valid = 1'b0;
    check("zero_valid", {31'd0, out_valid}, 32'd1);
    check("zero_ill", {31'd0, out_illegal}, 32'd1);
    check("zero_wr", {31'd0, out_reg_write}, 32'd0);
    check("zero_mem", {28'd0, out_mem_op}, 32'd0);
    check("zero_pc", out_pc, 32'h404);

    out_ready = 1'b0;
    tick();
    check("hold_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    tick();
    check("rstbp_valid", {31'd0, out_valid}, 32'd0);
    check("rstbp_ill", {31'd0, out_illegal}, 32'd0);
    check("rstbp_pc", out_pc, 32'd0);
    check("rstbp_m_alu", {25'd0, m_out_alu_control}, 32'd0);
    reset = 1'b0;
    #1;
    check("rstbp_ready", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised successor to the core's combinational control decoder: it accepts one RV32I (optionally RV32M) instruction per cycle over a valid/ready handshake, decodes it into the core's control bundle and holds the result in an ID/EX output register. It adds backpressure, pipeline flush, illegal-instruction flagging and load-use hazard stalling, and sits between the fetch stage and the execute stage of the pipelined core.

## Interface
- XLEN, 32, width of PC path
- ENABLE_M, 0, 1 = decode RV32M (MUL..REMU); 0 = flag them illegal
- LOAD_BUBBLES, 1, stall cycles after a load issue for dependent instructions (0..3; 0 disables stalling)
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of output register and hazard state
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  output bundle valid
- out_ready  in  1  execute stage consumes bundle
- out_pc  out  XLEN  registered in_pc
- out_rd / out_rs1 / out_rs2  out  5 each  register indices (instr[11:7], [19:15], [24:20])
- out_alu_control  out  7  ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLL6 SLTU7 SRL8 SRA9 BEQ10 BNE11 BLT12 BGE13 BLTU14 BGEU15 PASSB16 MUL17 MULH18 MULHSU19 MULHU20 DIV21 DIVU22 REM23 REMU24
- out_alu_src  out  1  1 = immediate operand B
- out_imm_src  out  3  I0 S1 B2 J3 U4
- out_result_src  out  2  ALU0 MEM1 PC+4 2 PC+imm 3
- out_mem_op  out  4  none0 SW1 SH2 SB3 LW4 LH5 LB6 LBU7 LHU8
- out_reg_write, out_jump, out_branch, out_illegal  out  1 each

## Operation
- Decode table: LUI (alu16, src1, imm4, res0, wr); AUIPC (imm4, res3, wr); JAL (imm3, res2, jump, wr); JALR funct3=000 (alu0, src1, imm0, res2, jump, wr); BRANCH funct3 000/001/100/101/110/111 -> alu10..15, imm2, branch, reg_write=0; LOAD funct3 000/001/010/100/101 -> mem_op 6/5/4/7/8, alu0, src1, imm0, res1, wr; STORE 000/001/010 -> mem_op 3/2/1, alu0, src1, imm1, wr=0; OP-IMM: ADDI0 SLTI5 SLTIU7 XORI4 ORI3 ANDI2 SLLI6, funct3=101 with funct7 0000000 -> SRLI8, 0100000 -> SRAI9; OP: funct7 0000000 -> ADD0 SLL6 SLT5 SLTU7 XOR4 SRL8 OR3 AND2 by funct3; 0100000 with funct3 000 -> SUB1, 101 -> SRA9; 0000001 and ENABLE_M -> funct3 0..7 maps to alu 17..24.
- Any other opcode/funct3/funct7 combination, including all-zero word: out_illegal=1; reg_write, jump, branch, mem_op forced 0; other fields 0. Illegal bundles still handshake normally.
- Fields not listed for a format are 0 (no don't-cares).
- Operand use: rs1 used by all except LUI, AUIPC, JAL, illegal; rs2 used by OP, STORE, BRANCH.
- Hazard: when a load bundle is consumed (out_valid & out_ready & mem_op in 4..8 & rd!=0), latch its rd and load counter with LOAD_BUBBLES. While counter!=0, an offered instruction using rs1 or rs2 equal to latched rd forces in_ready=0; counter decrements every cycle regardless. Non-dependent instructions pass.
- in_ready = (~out_valid | out_ready) & ~hazard_stall & ~flush.

## Timing
- Latency 1 cycle: accepted at edge N, out_valid and bundle visible after edge N.
- Bundle held stable while out_valid & ~out_ready.
- Consume and accept in same cycle: output register reloads, no bubble.
- Consume without accept: out_valid clears next edge.
- flush: next edge out_valid=0, hazard counter=0; in_ready=0 during flush so nothing accepted. Flush priority over consume and accept.
- reset: next edge every output register 0 (out_valid, all bundle fields, out_pc), counter 0, latched rd 0; in_ready=1 the cycle after reset deasserts. Reset mid-stall or mid-backpressure discards the held bundle.
- Counter does not wrap: saturates at 0.

## Test plan
- ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_control=0, reg_write=1, rd=3, rs1=1, rs2=2, illegal=0.
- SUB 0x402081B3 -> alu_control=1; SRAI 0x4020D193 -> alu_control=9, alu_src=1; BEQ 0x00208463 -> alu_control=10, branch=1, reg_write=0.
- LW x5,0(x1) 0x0000A283 then ADD x6,x5,x0 0x00028333, LOAD_BUBBLES=1 -> ADD held exactly one cycle (in_ready=0), then issued; ADD x6,x1,x2 instead -> no stall.
- out_ready=0 for 3 cycles with out_valid=1 -> bundle unchanged, in_ready=0; release -> next instruction appears one cycle later.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, instruction not accepted, pending hazard cleared.
- MUL 0x022081B3: ENABLE_M=0 -> illegal=1, reg_write=0; ENABLE_M=1 -> alu_control=17, reg_write=1; 0x00000000 -> illegal=1; reset mid-backpressure -> all outputs 0 next edge.
